// File: rtl/cordic_sched_pkg.sv
// Shared constants, op selects and FSM state codes for the CORDIC sequencer.
package cordic_sched_pkg;

    localparam logic [3:0] SEL_SIN  = 4'b0001;
    localparam logic [3:0] SEL_COS  = 4'b0010;
    localparam logic [3:0] SEL_TAN  = 4'b0100;
    localparam logic [3:0] SEL_ATAN = 4'b1000;

    localparam logic signed [15:0] DEG90  = 16'sd90;
    localparam logic signed [15:0] DEG180 = 16'sd180;
    localparam logic signed [15:0] DEG360 = 16'sd360;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_FOLD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_FIX   = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] s);
        return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/cordic_sched_rr_arb.sv
// Two-way round-robin grant; the requester not granted last wins a tie.
module cordic_sched_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic       idle,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] grant
);

    logic last;

    // Reset to "1 was last" so requester 0 is favoured first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= upd_id;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (idle) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Arbitrates requesters onto the shared CORDIC core, range-reduces the angle,
// waits for the core result and applies the quadrant sign correction.
module cordic_sched
    import cordic_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*16-1:0]  req_angle,
    input  logic [NREQ*16-1:0]  req_other,
    input  logic [NREQ*4-1:0]   req_sel,
    output logic [NREQ-1:0]     rsp_valid,
    output logic signed [15:0]  rsp_data,
    output logic                rsp_err,
    output logic                cor_valid,
    output logic [15:0]         cor_angle,
    output logic [15:0]         cor_another,
    output logic [3:0]          cor_select,
    input  logic signed [15:0]  cor_out,
    input  logic                cor_out_valid,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

    function automatic logic signed [15:0] sat_neg(input logic signed [15:0] v);
        if (v == 16'sh8000) return 16'sh7fff;
        return -v;
    endfunction

    function automatic logic signed [15:0] sat_abs(input logic signed [15:0] v);
        return (v < 16'sd0) ? sat_neg(v) : v;
    endfunction

    function automatic logic [1:0] quadrant(input logic signed [15:0] a);
        if (a < DEG90)               return 2'd0;
        else if (a < DEG180)         return 2'd1;
        else if (a < DEG360 - DEG90) return 2'd2;
        else                         return 2'd3;
    endfunction

    function automatic logic signed [15:0] fold_angle(input logic signed [15:0] a);
        case (quadrant(a))
            2'd0:    return a;
            2'd1:    return DEG180 - a;
            2'd2:    return a - DEG180;
            default: return DEG360 - a;
        endcase
    endfunction

    function automatic logic fold_neg(input logic [3:0] sel, input logic [1:0] q);
        case (sel)
            SEL_SIN: return q[1];
            SEL_COS: return q[1] ^ q[0];
            SEL_TAN: return q[0];
            default: return 1'b0;
        endcase
    endfunction

    state_t                    state, state_nxt;
    logic [1:0]                grant;
    logic                      acc, acc_id;
    logic signed [15:0]        acc_angle;
    logic [15:0]               acc_other;
    logic [3:0]                acc_sel;
    logic                      owner;
    logic [3:0]                sel_q;
    logic signed [15:0]        ang;
    logic [15:0]               other_q;
    logic                      neg;
    logic signed [15:0]        cap;
    logic [CNT_W-1:0]          cnt;
    logic                      is_atan;

    cordic_sched_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1:0]),
        .idle      (state == S_IDLE),
        .upd       (state == S_RESP),
        .upd_id    (owner),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign acc       = |(req_valid & grant);
    assign acc_id    = grant[1];
    assign acc_angle = acc_id ? $signed(req_angle[31:16]) : $signed(req_angle[15:0]);
    assign acc_other = acc_id ? req_other[31:16] : req_other[15:0];
    assign acc_sel   = acc_id ? req_sel[7:4] : req_sel[3:0];
    assign is_atan   = (sel_q == SEL_ATAN);
    assign busy      = (state != S_IDLE);
    assign cor_valid = (state == S_ISSUE);

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) rsp_valid[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc) state_nxt = is_onehot4(acc_sel) ? S_NORM : S_RESP;
            S_NORM:  if (is_atan || (ang >= 16'sd0 && ang < DEG360)) state_nxt = S_FOLD;
            S_FOLD:  state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cor_out_valid)    state_nxt = S_FIX;
                else if (cnt == TMAX) state_nxt = S_RESP;
            end
            S_FIX:   state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control and visible outputs: cleared by reset so an in-flight op is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            sel_q       <= '0;
            cnt         <= '0;
            cor_angle   <= '0;
            cor_another <= '0;
            cor_select  <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (acc) begin
                    owner    <= acc_id;
                    sel_q    <= acc_sel;
                    rsp_err  <= ~is_onehot4(acc_sel);
                    rsp_data <= '0;
                end
                S_FOLD: begin
                    cor_angle   <= is_atan ? sat_abs(ang) : fold_angle(ang);
                    cor_another <= is_atan ? other_q : 16'd0;
                    cor_select  <= sel_q;
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (!cor_out_valid && cnt == TMAX) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                S_FIX: rsp_data <= neg ? sat_neg(cap) : cap;
                default: ;
            endcase
        end
    end

    // Datapath registers: always written before being read within an op.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (acc) begin
                ang     <= acc_angle;
                other_q <= acc_other;
            end
            S_NORM: if (!is_atan) begin
                if (ang < 16'sd0)        ang <= ang + DEG360;
                else if (ang >= DEG360)  ang <= ang - DEG360;
            end
            S_FOLD: neg <= is_atan ? ang[15] : fold_neg(sel_q, quadrant(ang));
            S_WAIT: if (cor_out_valid) cap <= cor_out;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural model + fixed-latency core model, directed ops.
module tb_cordic_sched;

    localparam int L  = 8;
    localparam int TO = 255;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_angle;
    logic [31:0] req_other;
    logic [7:0]  req_sel;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        cor_valid;
    logic [15:0] cor_angle;
    logic [15:0] cor_another;
    logic [3:0]  cor_select;
    logic [15:0] cor_out;
    logic        cor_out_valid;
    logic        busy;

    cordic_sched #(.NREQ(2), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_angle     (req_angle),
        .req_other     (req_other),
        .req_sel       (req_sel),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .cor_valid     (cor_valid),
        .cor_angle     (cor_angle),
        .cor_another   (cor_another),
        .cor_select    (cor_select),
        .cor_out       (cor_out),
        .cor_out_valid (cor_out_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] angle;
        logic [15:0] other;
        logic [3:0]  sel;
        logic [15:0] core;
        bit          silent;
    } op_t;

    typedef struct packed {
        int          owner;
        logic [15:0] data;
        bit          err;
        int          cyc;
    } rsp_t;

    typedef struct packed {
        logic [15:0] angle;
        logic [15:0] another;
        logic [3:0]  sel;
    } iss_t;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t exp_rsp[$];
    iss_t exp_iss[$];
    int   grant_log[$];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int last_owner = 1;
    int iss_count = 0;
    logic [15:0] cur_core = 16'd0;
    bit          cur_silent = 1'b0;
    logic [15:0] last_cor_angle, last_cor_another, last_rsp_data;
    logic        last_rsp_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference rules: plain modular arithmetic on degrees.
    function automatic int norm_deg(input int a);
        return ((a % 360) + 360) % 360;
    endfunction

    function automatic int norm_steps(input int a);
        if (a < 0) return (-a + 359) / 360;
        return a / 360;
    endfunction

    function automatic int fold_deg(input int n);
        if (n < 90)  return n;
        if (n < 180) return 180 - n;
        if (n < 270) return n - 180;
        return 360 - n;
    endfunction

    function automatic bit neg_of(input logic [3:0] sel, input int n);
        int q;
        q = n / 90;
        case (sel)
            4'b0001: return q >= 2;
            4'b0010: return q == 1 || q == 2;
            4'b0100: return q == 1 || q == 3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] fix_val(input logic [15:0] core, input bit neg);
        if (!neg) return core;
        if (core == 16'h8000) return 16'h7fff;
        return 16'(-int'($signed(core)));
    endfunction

    op_t  hop;
    rsp_t er;
    iss_t ei;
    int   a_i, n_i, st_i, mag;
    bit   ng;

    always @(negedge clk) begin
        if (req_ready != 2'b00)
            chk("ready_rule", {30'd0, busy, req_ready == 2'b11}, 32'd0);

        if (cor_valid) begin
            iss_count++;
            if (exp_iss.size() == 0) begin
                chk("unexpected_issue", {31'd0, cor_valid}, 32'd0);
            end else begin
                ei = exp_iss.pop_front();
                chk("iss_angle", {16'd0, cor_angle}, {16'd0, ei.angle});
                chk("iss_another", {16'd0, cor_another}, {16'd0, ei.another});
                chk("iss_select", {28'd0, cor_select}, {28'd0, ei.sel});
            end
            last_cor_angle   = cor_angle;
            last_cor_another = cor_another;
        end

        if (rsp_valid != 2'b00) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                er = exp_rsp.pop_front();
                chk("rsp_owner", {30'd0, rsp_valid}, 32'd1 << er.owner);
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, er.data});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, er.err});
                chk("rsp_cycle", cyc, er.cyc);
                last_owner = er.owner;
            end
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
        end

        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (req_valid == 2'b11) chk("rr_winner", i, 1 - last_owner);
                hop = (i == 0) ? q0.pop_front() : q1.pop_front();
                grant_log.push_back(i);
                cur_core   = hop.core;
                cur_silent = hop.silent;
                a_i  = int'($signed(hop.angle));
                st_i = 0;
                ng   = 1'b0;
                er.owner = i;
                if (!$onehot(hop.sel)) begin
                    er.data = 16'd0;
                    er.err  = 1'b1;
                    er.cyc  = cyc + 1;
                end else begin
                    if (hop.sel == 4'b1000) begin
                        mag = (a_i < 0) ? ((a_i == -32768) ? 32767 : -a_i) : a_i;
                        ng  = (a_i < 0);
                        ei.angle   = 16'(mag);
                        ei.another = hop.other;
                    end else begin
                        n_i  = norm_deg(a_i);
                        st_i = norm_steps(a_i);
                        ng   = neg_of(hop.sel, n_i);
                        ei.angle   = 16'(fold_deg(n_i));
                        ei.another = 16'd0;
                    end
                    ei.sel = hop.sel;
                    exp_iss.push_back(ei);
                    if (hop.silent) begin
                        er.data = 16'd0;
                        er.err  = 1'b1;
                        er.cyc  = cyc + 3 + st_i + TO + 2;
                    end else begin
                        er.data = fix_val(hop.core, ng);
                        er.err  = 1'b0;
                        er.cyc  = cyc + 5 + L + st_i;
                    end
                end
                exp_rsp.push_back(er);
            end
        end
    end

    // Requester drivers: present the head of each queue until it is accepted.
    initial begin
        req_valid = 2'b00;
        req_angle = '0;
        req_other = '0;
        req_sel   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                req_valid[0]     = 1'b1;
                req_angle[15:0]  = q0[0].angle;
                req_other[15:0]  = q0[0].other;
                req_sel[3:0]     = q0[0].sel;
            end else begin
                req_valid[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                req_valid[1]     = 1'b1;
                req_angle[31:16] = q1[0].angle;
                req_other[31:16] = q1[0].other;
                req_sel[7:4]     = q1[0].sel;
            end else begin
                req_valid[1] = 1'b0;
            end
        end
    end

    // Core model: fixed latency L after the issue cycle, optionally silent.
    logic [15:0] core_v;
    initial begin
        cor_out       = 16'd0;
        cor_out_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (cor_valid && !cur_silent) begin
                core_v = cur_core;
                repeat (L) @(posedge clk);
                #1;
                cor_out       = core_v;
                cor_out_valid = 1'b1;
                @(posedge clk);
                #1;
                cor_out_valid = 1'b0;
                cor_out       = 16'd0;
            end
        end
    end

    task automatic push_op(input int id, input int angle, input int other, input logic [3:0] sel,
                           input logic [15:0] core, input bit silent);
        op_t o;
        o.angle  = 16'(angle);
        o.other  = 16'(other);
        o.sel    = sel;
        o.core   = core;
        o.silent = silent;
        if (id == 0) q0.push_back(o);
        else         q1.push_back(o);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || exp_rsp.size() != 0 || busy) && n < budget);
        chk({name, "_done"}, {28'd0, exp_rsp.size() != 0, q0.size() != 0, q1.size() != 0, busy}, 32'd0);
    endtask

    int base;
    int nw;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_cor_valid", {31'd0, cor_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outputs", {cor_angle, cor_another}, 32'd0);
        chk("rst_sel_data", {12'd0, cor_select, rsp_data}, 32'd0);
        chk("rst_err_ready", {29'd0, rsp_err, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        push_op(0, 210, 0, 4'b0001, 16'h0080, 1'b0);
        wait_done("sin210", 60);
        chk("sin210_angle", {16'd0, last_cor_angle}, 32'd30);
        chk("sin210_data", {16'd0, last_rsp_data}, 32'h0000FF80);
        chk("sin210_err", {31'd0, last_rsp_err}, 32'd0);

        push_op(0, -450, 0, 4'b0010, 16'h0000, 1'b0);
        wait_done("cos_m450", 60);
        chk("cosm450_angle", {16'd0, last_cor_angle}, 32'd90);
        chk("cosm450_data", {16'd0, last_rsp_data}, 32'h00000000);

        push_op(0, -256, 256, 4'b1000, 16'h2D00, 1'b0);
        wait_done("atan", 60);
        chk("atan_angle", {16'd0, last_cor_angle}, 32'd256);
        chk("atan_another", {16'd0, last_cor_another}, 32'd256);
        chk("atan_data", {16'd0, last_rsp_data}, 32'h0000D300);

        push_op(0, 200, 0, 4'b0001, 16'h8000, 1'b0);
        wait_done("sat", 60);
        chk("sat_angle", {16'd0, last_cor_angle}, 32'd20);
        chk("sat_data", {16'd0, last_rsp_data}, 32'h00007FFF);

        push_op(0, -32768, 100, 4'b1000, 16'h1000, 1'b0);
        wait_done("atan_min", 60);
        chk("atanmin_angle", {16'd0, last_cor_angle}, 32'd32767);
        chk("atanmin_data", {16'd0, last_rsp_data}, 32'h0000F000);

        push_op(0, -32768, 0, 4'b0001, 16'h0100, 1'b0);
        wait_done("norm_max", 160);

        push_op(1, 135, 0, 4'b0100, 16'h0100, 1'b0);
        wait_done("tan135", 60);
        chk("tan135_angle", {16'd0, last_cor_angle}, 32'd45);
        chk("tan135_data", {16'd0, last_rsp_data}, 32'h0000FF00);

        grant_log.delete();
        push_op(0, 30, 0, 4'b0001, 16'h0040, 1'b0);
        push_op(0, 60, 0, 4'b0010, 16'h0080, 1'b0);
        push_op(1, -30, 0, 4'b0001, 16'h0040, 1'b0);
        push_op(1, 400, 0, 4'b0010, 16'h00C4, 1'b0);
        wait_done("rr", 200);
        chk("rr_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("rr_order", grant_log[k], k % 2);
        end

        base = iss_count;
        push_op(0, 10, 0, 4'b0011, 16'h1111, 1'b0);
        wait_done("illegal", 20);
        chk("illegal_err", {31'd0, last_rsp_err}, 32'd1);
        chk("illegal_data", {16'd0, last_rsp_data}, 32'd0);
        chk("illegal_no_issue", iss_count - base, 32'd0);

        push_op(0, 30, 0, 4'b0001, 16'h0000, 1'b1);
        wait_done("timeout", 400);
        chk("timeout_err", {31'd0, last_rsp_err}, 32'd1);
        chk("timeout_data", {16'd0, last_rsp_data}, 32'd0);

        base = iss_count;
        push_op(0, 45, 0, 4'b0001, 16'h1234, 1'b0);
        nw = 0;
        while (iss_count == base && nw < 50) begin
            @(negedge clk);
            nw++;
        end
        chk("rstwait_issued", iss_count - base, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_rsp.delete();
        exp_iss.delete();
        #1;
        chk("rstwait_busy", {31'd0, busy}, 32'd0);
        chk("rstwait_rsp", {30'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_owner = 1;
        repeat (L + 4) @(negedge clk);
        push_op(0, 90, 0, 4'b0001, 16'h0100, 1'b0);
        wait_done("after_rst", 60);
        chk("afterrst_angle", {16'd0, last_cor_angle}, 32'd90);
        chk("afterrst_data", {16'd0, last_rsp_data}, 32'h00000100);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
